// File: rtl/counter_mmio_reader.sv
// Performance-counter MMIO read responder: cycle/instret counters, 1-cycle load response, clear-on-store.
// Ports: clk, rst (async, active-high), stall, rd_en, wbe[3:0], addr[31:0], EXMinst[31:0] in;
//        hit (comb), rd_data[31:0], rd_valid (registered) out.
// Optional branch counter at BR_ADDR enabled by defining CNT_BRANCH_EN.
module counter_mmio_reader #(
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] CYC_ADDR  = 32'h8000_0010,
  parameter logic [31:0] INST_ADDR = 32'h8000_0014,
  parameter logic [31:0] CLR_ADDR  = 32'h8000_0018
`ifdef CNT_BRANCH_EN
  ,
  parameter logic [31:0] BR_ADDR   = 32'h8000_001C
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        rd_en,
  input  logic [3:0]  wbe,
  input  logic [31:0] addr,
  input  logic [31:0] EXMinst,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        rd_valid
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_inst;
  logic             r_rd_valid;
  logic [31:0]      r_rd_data;

  logic             w_store;
  logic             w_clr;
  logic             w_nop;
  logic             w_inst_inc;
  logic             w_acc;
  logic             w_hit_cyc;
  logic             w_hit_inst;
  logic             w_hit_br;
  logic             w_hit;
  logic [CNT_W-1:0] w_sel;
  logic [31:0]      w_ext;

  assign w_store    = |wbe;
  assign w_clr      = w_store && (addr == CLR_ADDR) && !stall;
  assign w_nop      = (EXMinst == 32'h0000_0000) ||
                      (EXMinst == 32'h0000_0013);
  assign w_inst_inc = !stall && !w_nop;

  // A store sharing the cycle with rd_en suppresses the read.
  assign w_acc      = rd_en && !stall && !w_store &&
                      (addr[1:0] == 2'b00);
  assign w_hit_cyc  = w_acc && (addr == CYC_ADDR);
  assign w_hit_inst = w_acc && (addr == INST_ADDR);

`ifdef CNT_BRANCH_EN
  logic [CNT_W-1:0] r_br;
  logic             w_br_inc;

  assign w_br_inc = !stall && (EXMinst[6:0] == 7'b1100011);
  assign w_hit_br = w_acc && (addr == BR_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br <= '0;
    end else if (w_clr) begin
      r_br <= '0;
    end else if (w_br_inc) begin
      r_br <= r_br + ONE;
    end
  end
`else
  assign w_hit_br = 1'b0;
`endif

  assign w_hit = w_hit_cyc || w_hit_inst || w_hit_br;
  assign hit   = w_hit;

  always_comb begin
    w_sel = '0;
    unique case (1'b1)
      w_hit_cyc:  w_sel = r_cyc;
      w_hit_inst: w_sel = r_inst;
`ifdef CNT_BRANCH_EN
      w_hit_br:   w_sel = r_br;
`endif
      default:    w_sel = '0;
    endcase
  end

  always_comb begin
    w_ext            = '0;
    w_ext[CNT_W-1:0] = w_sel;
  end

  // Clear beats increment: the edge after a clear leaves 0, not 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc  <= '0;
      r_inst <= '0;
    end else if (w_clr) begin
      r_cyc  <= '0;
      r_inst <= '0;
    end else begin
      r_cyc <= r_cyc + ONE;
      if (w_inst_inc) begin
        r_inst <= r_inst + ONE;
      end
    end
  end

  // Response carries the counter value seen in the request cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_hit;
      r_rd_data  <= w_hit ? w_ext : 32'h0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule
